// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data load/store.
// Data has priority, bounded by a streak guard; hung transactions are aborted by a timeout.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  if_cmd,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic [1:0]  dm_cmd,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_error
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] d_streak;
  logic [CW-1:0] to_cnt;
  logic          discard;

  logic dm_valid, if_req, dm_req, grant_d, grant_i, busy, finish;

  // A port in its done-pulse cycle still shows the old request and must not be re-granted.
  assign dm_valid = (dm_cmd == BUS_LOAD) || (dm_cmd == BUS_STORE);
  assign if_req   = (if_cmd == BUS_LOAD) && !if_done;
  assign dm_req   = dm_valid && !dm_done;
  assign grant_d  = dm_req && (!if_req || (d_streak != SW'(MAX_D_STREAK)));
  assign grant_i  = if_req && !grant_d;
  assign busy     = (state == ST_IBUSY) || (state == ST_DBUSY);
  assign finish   = busy && (mem_ready || (to_cnt == CW'(TIMEOUT_CYCLES - 1)));

  assign if_stall = (if_cmd == BUS_LOAD) && !if_done;
  assign dm_stall = dm_valid && !dm_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      d_streak  <= '0;
      to_cnt    <= '0;
      discard   <= 1'b0;
      mem_cmd   <= BUS_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (!busy) begin
        state <= ST_IDLE;
        if (grant_d) begin
          state     <= ST_DBUSY;
          mem_cmd   <= dm_cmd;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          to_cnt    <= '0;
          // Cannot overflow: with fetch waiting, data only wins below the limit.
          if (if_req) d_streak <= d_streak + SW'(1);
        end else if (grant_i) begin
          state     <= ST_IBUSY;
          mem_cmd   <= BUS_LOAD;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          to_cnt    <= '0;
          d_streak  <= '0;
        end
      end else begin
        if ((state == ST_IBUSY) && if_flush) discard <= 1'b1;
        if (finish) begin
          state   <= ST_IDLE;
          mem_cmd <= BUS_NONE;
          discard <= 1'b0;
          if (!mem_ready) bus_error <= 1'b1;
          if (state == ST_IBUSY) begin
            if (!(discard || if_flush)) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            dm_done <= 1'b1;
            // Stores keep the last load value unless aborted.
            if (!mem_ready || (mem_cmd == BUS_LOAD)) dm_rdata <= mem_ready ? mem_rdata : '0;
          end
        end else begin
          to_cnt <= to_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 64;

  logic        clk, rst;
  logic [1:0]  if_cmd;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done, if_stall;
  logic [1:0]  dm_cmd;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_done, dm_stall;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, bus_error;

  int n_chk, n_fail;
  logic [31:0] last_ir;

  mem_bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_cmd(if_cmd), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_cmd = 2'd0; if_addr = '0; if_flush = 1'b0;
    dm_cmd = 2'd0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    step(); step(); #1;
    n_chk++;
    if ({mem_cmd, mem_addr, mem_wdata} !== 66'd0) begin
      n_fail++; $display("FAIL rst_bus got %h/%h/%h want 0", mem_cmd, mem_addr, mem_wdata);
    end
    n_chk++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL rst_rdata got %h/%h want 0", if_rdata, dm_rdata);
    end
    n_chk++;
    if ({if_done, dm_done, bus_error, if_stall, dm_stall} !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 00000", {if_done, dm_done, bus_error, if_stall, dm_stall});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    step(); if_cmd = 2'd1; if_addr = 32'h100; #1;
    n_chk++;
    if ({if_stall, mem_cmd} !== 3'b100) begin
      n_fail++; $display("FAIL f_req got stall=%b cmd=%0d want 1/0", if_stall, mem_cmd);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h1234_5678; end
      #1;
      n_chk++;
      if (mem_cmd !== 2'd1 || mem_addr !== 32'h100 || if_done !== 1'b0) begin
        n_fail++;
        $display("FAIL f_busy%0d got cmd=%0d addr=%h done=%b want 1/100/0", c, mem_cmd, mem_addr,
                 if_done);
      end
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if (if_done !== 1'b1 || if_rdata !== 32'h1234_5678 || mem_cmd !== 2'd0 || if_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL f_done got done=%b rd=%h cmd=%0d stall=%b want 1/12345678/0/0", if_done,
               if_rdata, mem_cmd, if_stall);
    end
    step(); if_cmd = 2'd0; #1;
    n_chk++;
    if (if_done !== 1'b0 || mem_cmd !== 2'd0) begin
      n_fail++; $display("FAIL f_noregrant got done=%b cmd=%0d want 0/0", if_done, mem_cmd);
    end
    last_ir = 32'h1234_5678;
  endtask

  task automatic test_back_to_back();
    step();
    if_cmd = 2'd1; if_addr = 32'h300;
    dm_cmd = 2'd2; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; #1;
    n_chk++;
    if ({if_stall, dm_stall} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_stalls got %b want 11", {if_stall, dm_stall});
    end
    step(); mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    n_chk++;
    if (mem_cmd !== 2'd2 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || !if_stall) begin
      n_fail++;
      $display("FAIL b2b_store got cmd=%0d addr=%h wd=%h istall=%b want 2/200/deadbeef/1", mem_cmd,
               mem_addr, mem_wdata, if_stall);
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if ({dm_done, dm_stall, if_stall} !== 3'b101 || mem_cmd !== 2'd0 || dm_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_sdone got done/dstall/istall=%b cmd=%0d drd=%h want 101/0/0",
               {dm_done, dm_stall, if_stall}, mem_cmd, dm_rdata);
    end
    step(); dm_cmd = 2'd0; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    n_chk++;
    if (mem_cmd !== 2'd1 || mem_addr !== 32'h300 || mem_wdata !== 32'd0 || !if_stall) begin
      n_fail++;
      $display("FAIL b2b_fetch got cmd=%0d addr=%h wd=%h stall=%b want 1/300/0/1", mem_cmd, mem_addr,
               mem_wdata, if_stall);
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if (if_done !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL b2b_fdone got done=%b rd=%h want 1/0badf00d", if_done, if_rdata);
    end
    step(); if_cmd = 2'd0;
    last_ir = 32'h0BAD_F00D;
  endtask

  // The fetch withdraws after each losing round so that the streak builds up to the limit.
  task automatic test_streak();
    logic [31:0] da;
    for (int r = 0; r < 4; r++) begin
      da = 32'h900 + 32'(r * 4);
      step(); if_cmd = 2'd1; if_addr = 32'h800; dm_cmd = 2'd1; dm_addr = da; #1;
      step(); if_cmd = 2'd0; mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(r); #1;
      n_chk++;
      if (mem_cmd !== 2'd1 || mem_addr !== da) begin
        n_fail++; $display("FAIL streak_d%0d got cmd=%0d addr=%h want 1/%h", r, mem_cmd, mem_addr, da);
      end
      step(); mem_ready = 1'b0; #1;
      n_chk++;
      if (dm_done !== 1'b1 || dm_rdata !== 32'h1000 + 32'(r)) begin
        n_fail++; $display("FAIL streak_dd%0d got done=%b rd=%h", r, dm_done, dm_rdata);
      end
      step(); dm_cmd = 2'd0;
    end
    step(); if_cmd = 2'd1; if_addr = 32'h800; dm_cmd = 2'd1; dm_addr = 32'h990; #1;
    step(); mem_ready = 1'b1; mem_rdata = 32'h2000; #1;
    n_chk++;
    if (mem_cmd !== 2'd1 || mem_addr !== 32'h800) begin
      n_fail++; $display("FAIL streak_forced got cmd=%0d addr=%h want 1/800", mem_cmd, mem_addr);
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if (if_done !== 1'b1 || if_rdata !== 32'h2000 || dm_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL streak_fdone got done=%b rd=%h dstall=%b want 1/2000/1", if_done, if_rdata,
               dm_stall);
    end
    step(); if_cmd = 2'd0; mem_ready = 1'b1; mem_rdata = 32'h3000; #1;
    n_chk++;
    if (mem_addr !== 32'h990) begin
      n_fail++; $display("FAIL streak_after got addr=%h want 990", mem_addr);
    end
    step(); mem_ready = 1'b0; #1;
    step(); dm_cmd = 2'd0;
    step(); if_cmd = 2'd1; if_addr = 32'h804; dm_cmd = 2'd1; dm_addr = 32'h994; #1;
    step(); if_cmd = 2'd0; mem_ready = 1'b1; mem_rdata = 32'h3004; #1;
    n_chk++;
    if (mem_addr !== 32'h994) begin
      n_fail++; $display("FAIL streak_cleared got addr=%h want 994", mem_addr);
    end
    step(); mem_ready = 1'b0; #1;
    step(); dm_cmd = 2'd0;
    last_ir = 32'h2000;
  endtask

  task automatic test_timeout();
    step(); dm_cmd = 2'd1; dm_addr = 32'h400; #1;
    for (int c = 1; c <= 64; c++) begin
      step(); #1;
      n_chk++;
      if (mem_cmd !== 2'd1 || bus_error !== 1'b0 || dm_done !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_wait%0d got cmd=%0d err=%b done=%b want 1/0/0", c, mem_cmd, bus_error,
                 dm_done);
      end
    end
    step(); #1;
    n_chk++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'd0 || bus_error !== 1'b1 || mem_cmd !== 2'd0) begin
      n_fail++;
      $display("FAIL tmo_abort got done=%b rd=%h err=%b cmd=%0d want 1/0/1/0", dm_done, dm_rdata,
               bus_error, mem_cmd);
    end
    step(); dm_addr = 32'h404; #1;
    step(); mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    n_chk++;
    if (mem_cmd !== 2'd1 || mem_addr !== 32'h404) begin
      n_fail++; $display("FAIL tmo_next got cmd=%0d addr=%h want 1/404", mem_cmd, mem_addr);
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'hCAFE_F00D || bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky got done=%b rd=%h err=%b want 1/cafef00d/1", dm_done, dm_rdata,
               bus_error);
    end
    step(); dm_cmd = 2'd0;
  endtask

  task automatic test_flush();
    step(); if_cmd = 2'd1; if_addr = 32'h500; #1;
    step(); #1;
    step(); if_flush = 1'b1; #1;
    step(); if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_5555; #1;
    step(); mem_ready = 1'b0; if_addr = 32'h600; #1;
    n_chk++;
    if (if_done !== 1'b0 || if_rdata !== last_ir || mem_cmd !== 2'd0 || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drop got done=%b rd=%h cmd=%0d stall=%b want 0/%h/0/1", if_done, if_rdata,
               mem_cmd, if_stall, last_ir);
    end
    step(); mem_ready = 1'b1; mem_rdata = 32'h6666_6666; #1;
    n_chk++;
    if (mem_cmd !== 2'd1 || mem_addr !== 32'h600) begin
      n_fail++; $display("FAIL flush_new got cmd=%0d addr=%h want 1/600", mem_cmd, mem_addr);
    end
    step(); mem_ready = 1'b0; #1;
    n_chk++;
    if (if_done !== 1'b1 || if_rdata !== 32'h6666_6666) begin
      n_fail++; $display("FAIL flush_done got done=%b rd=%h want 1/66666666", if_done, if_rdata);
    end
    step(); if_cmd = 2'd0;
  endtask

  task automatic test_reset_mid();
    step(); dm_cmd = 2'd1; dm_addr = 32'h700; #1;
    step(); #1;
    step(); rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777; #1;
    n_chk++;
    if ({mem_cmd, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done, bus_error} !== 133'd0)
    begin
      n_fail++;
      $display("FAIL rstmid got cmd=%0d addr=%h drd=%h ddone=%b err=%b want all 0", mem_cmd,
               mem_addr, dm_rdata, dm_done, bus_error);
    end
    step(); dm_cmd = 2'd0; mem_ready = 1'b0; rst = 1'b0; #1;
    step(); #1;
    n_chk++;
    if (dm_done !== 1'b0 || mem_cmd !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_idle got done=%b cmd=%0d want 0/0", dm_done, mem_cmd);
    end
  endtask

  // Model: owner 0 = bus free, 1 = fetch, 2 = data; age counts busy cycles.
  task automatic test_random();
    int owner = 0, age = 0, streak = 0;
    bit drop = 0, err = 0, e_id = 0, e_dd = 0, f_act = 0, d_act = 0, f_rel = 0, d_rel = 0;
    bit fw, dw, tmo, nid, ndd;
    logic [1:0]  e_cmd = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ir = 0, e_dr = 0, val;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (f_rel || !f_act) begin
        f_rel = 0;
        if ($urandom_range(0, 2) == 0) begin
          f_act = 1; if_cmd = 2'd1; if_addr = $urandom;
        end else begin
          f_act = 0; if_cmd = 2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1));
          if (if_cmd == 2'd1) if_cmd = 2'd0;
        end
      end else if (owner != 1 && $urandom_range(0, 15) == 0) begin
        f_act = 0; if_cmd = 2'd0;
      end
      if (d_rel || !d_act) begin
        d_rel = 0;
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1; dm_cmd = 2'($urandom_range(1, 2)); dm_addr = $urandom; dm_wdata = $urandom;
        end else begin
          d_act = 0; dm_cmd = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        end
      end
      if_flush  = ($urandom_range(0, 11) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      n_chk++;
      if ({mem_cmd, mem_addr, mem_wdata} !== {e_cmd, e_addr, e_wdata}) begin
        n_fail++;
        $display("FAIL rnd_bus n=%0d got %0d/%h/%h want %0d/%h/%h", n, mem_cmd, mem_addr, mem_wdata,
                 e_cmd, e_addr, e_wdata);
      end
      n_chk++;
      if ({if_done, dm_done, bus_error} !== {e_id, e_dd, err}) begin
        n_fail++;
        $display("FAIL rnd_flags n=%0d got %b want %b", n, {if_done, dm_done, bus_error},
                 {e_id, e_dd, err});
      end
      n_chk++;
      if ({if_rdata, dm_rdata} !== {e_ir, e_dr}) begin
        n_fail++;
        $display("FAIL rnd_rdata n=%0d got %h/%h want %h/%h", n, if_rdata, dm_rdata, e_ir, e_dr);
      end
      n_chk++;
      if ({if_stall, dm_stall} !== {(if_cmd == 2'd1) && !e_id,
                                     (dm_cmd == 2'd1 || dm_cmd == 2'd2) && !e_dd}) begin
        n_fail++;
        $display("FAIL rnd_stall n=%0d got %b if_cmd=%0d dm_cmd=%0d", n, {if_stall, dm_stall},
                 if_cmd, dm_cmd);
      end
      f_rel = e_id; d_rel = e_dd;
      nid = 0; ndd = 0;
      if (owner == 0) begin
        fw = (if_cmd == 2'd1) && !e_id;
        dw = (dm_cmd == 2'd1 || dm_cmd == 2'd2) && !e_dd;
        if (dw && (!fw || streak < int'(MAXS))) begin
          owner = 2; e_cmd = dm_cmd; e_addr = dm_addr; e_wdata = dm_wdata; age = 0;
          if (fw) streak++;
        end else if (fw) begin
          owner = 1; e_cmd = 2'd1; e_addr = if_addr; e_wdata = 0; age = 0; streak = 0;
        end
      end else begin
        if (owner == 1 && if_flush) drop = 1;
        tmo = !mem_ready && (age == int'(TMO) - 1);
        if (mem_ready || tmo) begin
          val = tmo ? 32'd0 : mem_rdata;
          if (tmo) err = 1;
          if (owner == 1) begin
            if (!drop) begin nid = 1; e_ir = val; end
          end else begin
            ndd = 1;
            if (tmo || e_cmd == 2'd1) e_dr = val;
          end
          owner = 0; e_cmd = 0; drop = 0;
        end else begin
          age++;
        end
      end
      e_id = nid; e_dd = ndd;
    end
    step(); idle_in();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; last_ir = 0;
    test_reset();
    test_fetch_only();
    test_back_to_back();
    test_streak();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

endmodule
